weight_bias_update: RTL and testbench
=====================================

WEIGHT_BIAS_UPDATE -- requirements
Module: weight_bias_update

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  N_IN  2  input-layer width
  N_HL_P  3  hidden-layer perceptrons
  N_OUT  2  output-layer perceptrons
  WIDTH  32  signed fixed-point word width
REQ-002 P = N_OUT + N_HL_P + N_HL_P*N_OUT + N_HL_P*N_IN (17 at defaults) SHALL be the total parameter count.
REQ-003 Ports SHALL be, one per line: name, direction, width, meaning.
  clk  in  1  sole clock; all state updates on rising edge
  rst  in  1  reset, synchronous, active-high
  i_load  in  1  load initial parameters (IDLE only)
  i_start  in  1  start one update pass (IDLE only)
  i_shift  in  5  arithmetic right shift applied to every delta (batch averaging)
  i_d_bias_o  in  N_OUT*WIDTH  accumulated output-bias deltas
  i_d_bias_hd  in  N_HL_P*WIDTH  accumulated hidden-bias deltas
  i_d_wght_o  in  N_HL_P*N_OUT*WIDTH  accumulated output-weight deltas
  i_d_wght_hd  in  N_HL_P*N_IN*WIDTH  accumulated hidden-weight deltas
  i_init_bias_o / i_init_bias_hd / i_init_wght_o / i_init_wght_hd  in  same widths as deltas  initial parameter values
  o_bias_o / o_bias_hd / o_wght_o / o_wght_hd  out  same widths as deltas  current parameter registers
  o_busy  out  1  high in CAP, UPD and DONE
  o_done  out  1  one-cycle pulse at end of pass
  o_acc_rst  out  1  one-cycle pulse clearing upstream delta accumulators
REQ-004 Packing of all vectors SHALL be element 0 in bits [WIDTH-1:0]; weight element index = perceptron*fan_in + source (o_11 lowest, then o_12, o_13, o_21...).

Function
REQ-005 Parameters SHALL be held as a flat array p[0..P-1]: bias_o, then bias_hd, then wght_o, then wght_hd, each in packing order; deltas d[] use the same indexing.
REQ-006 FSM states SHALL be IDLE, CAP, UPD, DONE.
REQ-007 IDLE with i_load=1: all p[] loaded from i_init_* next edge; stay IDLE; i_start ignored that cycle.
REQ-008 IDLE with i_start=1 and i_load=0: go to CAP.
REQ-009 CAP (one cycle): snapshot all d[] into shadow registers, latch i_shift, idx<=0, go to UPD.
REQ-010 UPD: each cycle p[idx] <= p[idx] - (snap[idx] >>> sh), sign-preserving shift; idx increments; after idx=P-1 go to DONE.
REQ-011 DONE (one cycle): o_done=1, o_acc_rst=1; go to IDLE.
REQ-012 Latency: i_start sampled at edge t -> o_done high during cycle t+P+1 (cycle t+18 at defaults); o_busy high cycles t+1..t+P+1.
REQ-013 i_start and i_load SHALL be ignored whenever o_busy=1.
REQ-014 Deltas SHALL be sampled only in CAP; input changes during UPD have no effect.
REQ-015 Only p[idx] SHALL change in a UPD cycle; o_* outputs reflect registers directly.
REQ-016 Subtraction SHALL be WIDTH-bit signed; overflow handling per REQ-020/021.

Reset
REQ-017 rst=1 at an edge SHALL force IDLE, all p[] = 0, snapshots = 0, idx = 0, o_busy = o_done = o_acc_rst = 0.
REQ-018 rst SHALL take priority over i_load/i_start; reset mid-pass SHALL abort with no o_done or o_acc_rst pulse.

Configuration
REQ-019 Macro WBU_SAT_EN SHALL select overflow behaviour.
REQ-020 WBU_SAT_EN defined: result clamps to 2^(WIDTH-1)-1 or -2^(WIDTH-1).
REQ-021 WBU_SAT_EN undefined: result wraps modulo 2^WIDTH.

Verification
REQ-022 rst, then i_load with all init = 0x00010000 -> all outputs 0x00010000; o_busy = 0.
REQ-023 All deltas = 0x00000400, i_shift = 2, i_start -> o_done exactly 18 cycles later, every parameter = 0x0000FF00, o_acc_rst coincident with o_done.
REQ-024 i_start pulsed again during UPD, then i_load during UPD -> no effect; single o_done; parameters as REQ-023.
REQ-025 p = 0x80000001, delta = 0x00000010, shift 0 -> 0x80000000 with WBU_SAT_EN; 0x7FFFFFF1 without.
REQ-026 Delta = 0xFFFFFF00 (negative), shift 4 -> parameter increases by 0x10.
REQ-027 rst asserted at idx = 8 -> p[0..16] = 0, IDLE next cycle, no o_done.

Source files
------------

// File: rtl/weight_bias_update_if.sv
`default_nettype none
// ============================================================================
// Module      : weight_bias_update_if
// Description : Control, delta, init and parameter bus of weight_bias_update.
// Revision    : 1.0  initial release
// ============================================================================
interface weight_bias_update_if #(
    parameter int N_IN   = 2,
    parameter int N_HL_P = 3,
    parameter int N_OUT  = 2,
    parameter int WIDTH  = 32
);
    logic                            i_load;
    logic                            i_start;
    logic [4:0]                      i_shift;
    logic [N_OUT*WIDTH-1:0]          i_d_bias_o;
    logic [N_HL_P*WIDTH-1:0]         i_d_bias_hd;
    logic [N_HL_P*N_OUT*WIDTH-1:0]   i_d_wght_o;
    logic [N_HL_P*N_IN*WIDTH-1:0]    i_d_wght_hd;
    logic [N_OUT*WIDTH-1:0]          i_init_bias_o;
    logic [N_HL_P*WIDTH-1:0]         i_init_bias_hd;
    logic [N_HL_P*N_OUT*WIDTH-1:0]   i_init_wght_o;
    logic [N_HL_P*N_IN*WIDTH-1:0]    i_init_wght_hd;
    logic [N_OUT*WIDTH-1:0]          o_bias_o;
    logic [N_HL_P*WIDTH-1:0]         o_bias_hd;
    logic [N_HL_P*N_OUT*WIDTH-1:0]   o_wght_o;
    logic [N_HL_P*N_IN*WIDTH-1:0]    o_wght_hd;
    logic                            o_busy;
    logic                            o_done;
    logic                            o_acc_rst;

    modport master (
        output i_load, i_start, i_shift,
        output i_d_bias_o, i_d_bias_hd, i_d_wght_o, i_d_wght_hd,
        output i_init_bias_o, i_init_bias_hd, i_init_wght_o, i_init_wght_hd,
        input  o_bias_o, o_bias_hd, o_wght_o, o_wght_hd,
        input  o_busy, o_done, o_acc_rst
    );

    modport slave (
        input  i_load, i_start, i_shift,
        input  i_d_bias_o, i_d_bias_hd, i_d_wght_o, i_d_wght_hd,
        input  i_init_bias_o, i_init_bias_hd, i_init_wght_o, i_init_wght_hd,
        output o_bias_o, o_bias_hd, o_wght_o, o_wght_hd,
        output o_busy, o_done, o_acc_rst
    );
endinterface
`default_nettype wire

// File: rtl/weight_bias_update.sv
`default_nettype none
// ============================================================================
// Module      : weight_bias_update
// Description : Sequential SGD step p[i] -= d[i] >>> shift, one parameter per
//               cycle. Define WBU_SAT_EN for saturating subtraction.
// Revision    : 1.0  initial release
// ============================================================================
module weight_bias_update #(
    parameter int N_IN   = 2,
    parameter int N_HL_P = 3,
    parameter int N_OUT  = 2,
    parameter int WIDTH  = 32
) (
    input  wire logic           clk,
    input  wire logic           rst,
    weight_bias_update_if.slave bus
);
    localparam int N_BO   = N_OUT;
    localparam int N_BH   = N_HL_P;
    localparam int N_WO   = N_HL_P * N_OUT;
    localparam int N_WH   = N_HL_P * N_IN;
    localparam int P      = N_BO + N_BH + N_WO + N_WH;
    localparam int OFF_BH = N_BO;
    localparam int OFF_WO = OFF_BH + N_BH;
    localparam int OFF_WH = OFF_WO + N_WO;
    localparam int IDXW   = (P > 1) ? $clog2(P) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CAP  = 2'd1;
    localparam logic [1:0] S_UPD  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]              state_q, state_d;
    logic signed [WIDTH-1:0] p_q    [P];
    logic signed [WIDTH-1:0] snap_q [P];
    logic [4:0]              sh_q;
    logic [IDXW-1:0]         idx_q;

    logic [P*WIDTH-1:0]      init_flat;
    logic [P*WIDTH-1:0]      delta_flat;
    logic [P*WIDTH-1:0]      p_flat;
    logic signed [WIDTH-1:0] upd_cur;
    logic signed [WIDTH-1:0] upd_dec;
    logic signed [WIDTH-1:0] upd_res;
    logic                    load_en;
    logic                    busy_c, done_c;

    // Element 0 of bias_o ends up in the lowest word of the flat vector.
    assign init_flat  = {bus.i_init_wght_hd, bus.i_init_wght_o,
                         bus.i_init_bias_hd, bus.i_init_bias_o};
    assign delta_flat = {bus.i_d_wght_hd, bus.i_d_wght_o,
                         bus.i_d_bias_hd, bus.i_d_bias_o};

    assign load_en = (state_q == S_IDLE) && bus.i_load;

    assign upd_cur = p_q[idx_q];
    assign upd_dec = snap_q[idx_q] >>> sh_q;

`ifdef WBU_SAT_EN
    localparam logic signed [WIDTH-1:0] C_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] C_MIN = {1'b1, {(WIDTH-1){1'b0}}};
    logic [WIDTH:0] upd_diff;

    // One guard bit: the top two bits disagree exactly on signed overflow.
    assign upd_diff = {upd_cur[WIDTH-1], upd_cur} - {upd_dec[WIDTH-1], upd_dec};

    always_comb begin
        upd_res = upd_diff[WIDTH-1:0];
        if (upd_diff[WIDTH] != upd_diff[WIDTH-1]) begin
            upd_res = upd_diff[WIDTH] ? C_MIN : C_MAX;
        end
    end
`else
    assign upd_res = upd_cur - upd_dec;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (!bus.i_load && bus.i_start) begin
                    state_d = S_CAP;
                end
            end
            S_CAP:  state_d = S_UPD;
            S_UPD: begin
                if (idx_q == IDXW'(P - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy_c = (state_q != S_IDLE);
        done_c = (state_q == S_DONE);
    end

    assign bus.o_busy    = busy_c;
    assign bus.o_done    = done_c;
    assign bus.o_acc_rst = done_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < P; i++) begin
                p_q[i] <= '0;
            end
        end else if (load_en) begin
            for (int i = 0; i < P; i++) begin
                p_q[i] <= init_flat[i*WIDTH +: WIDTH];
            end
        end else if (state_q == S_UPD) begin
            p_q[idx_q] <= upd_res;
        end
    end

    // Deltas and shift are frozen here so upstream may keep accumulating.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < P; i++) begin
                snap_q[i] <= '0;
            end
            sh_q  <= '0;
            idx_q <= '0;
        end else if (state_q == S_CAP) begin
            for (int i = 0; i < P; i++) begin
                snap_q[i] <= delta_flat[i*WIDTH +: WIDTH];
            end
            sh_q  <= bus.i_shift;
            idx_q <= '0;
        end else if (state_q == S_UPD) begin
            idx_q <= idx_q + IDXW'(1);
        end
    end

    for (genvar g = 0; g < P; g++) begin : g_flat
        assign p_flat[g*WIDTH +: WIDTH] = p_q[g];
    end

    assign bus.o_bias_o  = p_flat[0          +: N_BO*WIDTH];
    assign bus.o_bias_hd = p_flat[OFF_BH*WIDTH +: N_BH*WIDTH];
    assign bus.o_wght_o  = p_flat[OFF_WO*WIDTH +: N_WO*WIDTH];
    assign bus.o_wght_hd = p_flat[OFF_WH*WIDTH +: N_WH*WIDTH];

endmodule
`default_nettype wire

// File: tb/tb_weight_bias_update.sv
`default_nettype none
// ============================================================================
// Module      : tb_weight_bias_update
// Description : Self-checking bench for weight_bias_update (WBU_SAT_EN aware).
// Revision    : 1.0  initial release
// ============================================================================
module tb_weight_bias_update;
    localparam int N_IN   = 2;
    localparam int N_HL_P = 3;
    localparam int N_OUT  = 2;
    localparam int WIDTH  = 32;
    localparam int P      = N_OUT + N_HL_P + N_HL_P*N_OUT + N_HL_P*N_IN;
    localparam int B_BH   = N_OUT * WIDTH;
    localparam int B_WO   = B_BH + N_HL_P * WIDTH;
    localparam int B_WH   = B_WO + N_HL_P * N_OUT * WIDTH;
    localparam longint MAXV = (64'sd1 <<< (WIDTH-1)) - 1;
    localparam longint MINV = -(64'sd1 <<< (WIDTH-1));

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    weight_bias_update_if #(.N_IN(N_IN), .N_HL_P(N_HL_P), .N_OUT(N_OUT), .WIDTH(WIDTH)) bus ();

    weight_bias_update #(.N_IN(N_IN), .N_HL_P(N_HL_P), .N_OUT(N_OUT), .WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] dut_p(input int i);
        logic [P*WIDTH-1:0] f;
        f = {bus.o_wght_hd, bus.o_wght_o, bus.o_bias_hd, bus.o_bias_o};
        return f[i*WIDTH +: WIDTH];
    endfunction

    // New value of one parameter from the arithmetic rule alone.
    function automatic logic [WIDTH-1:0] upd(input logic [WIDTH-1:0] p, input logic [WIDTH-1:0] d,
                                             input int sh);
        longint a, b, r;
        a = longint'($signed(p));
        b = longint'($signed(d)) >>> sh;
        r = a - b;
`ifdef WBU_SAT_EN
        if (r > MAXV) r = MAXV;
        if (r < MINV) r = MINV;
`endif
        return r[WIDTH-1:0];
    endfunction

    // Timeline model: start sampled at edge st, CAP samples at st+1,
    // p[i] updated at edge st+2+i, DONE visible after edge st+P+1.
    logic [WIDTH-1:0] m_p    [P];
    logic [WIDTH-1:0] m_snap [P];
    int  m_sh, m_st, e, k;
    bit  m_pass = 0, m_busy = 0, m_done = 0, m_valid = 0;

    always @(posedge clk) begin
        logic [P*WIDTH-1:0] fi, fd;
        fi = {bus.i_init_wght_hd, bus.i_init_wght_o, bus.i_init_bias_hd, bus.i_init_bias_o};
        fd = {bus.i_d_wght_hd, bus.i_d_wght_o, bus.i_d_bias_hd, bus.i_d_bias_o};
        e++;
        if (rst) begin
            m_valid = 1;
            m_pass  = 0;
            for (int i = 0; i < P; i++) m_p[i] = '0;
        end else if (m_valid) begin
            if (!m_busy) begin
                if (bus.i_load) begin
                    for (int i = 0; i < P; i++) m_p[i] = fi[i*WIDTH +: WIDTH];
                end else if (bus.i_start) begin
                    m_pass = 1;
                    m_st   = e;
                end
            end else begin
                k = e - m_st;
                if (k == 1) begin
                    for (int i = 0; i < P; i++) m_snap[i] = fd[i*WIDTH +: WIDTH];
                    m_sh = int'(bus.i_shift);
                end else if (k >= 2 && k <= P + 1) begin
                    m_p[k-2] = upd(m_p[k-2], m_snap[k-2], m_sh);
                end else begin
                    m_pass = 0;
                end
            end
        end
        m_busy = m_pass && (e - m_st <= P + 1);
        m_done = m_pass && (e - m_st == P + 1);
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("busy", WIDTH'(bus.o_busy), WIDTH'(m_busy));
            chk("done", WIDTH'(bus.o_done), WIDTH'(m_done));
            chk("acc_rst", WIDTH'(bus.o_acc_rst), WIDTH'(m_done));
            for (int i = 0; i < P; i++) chk($sformatf("model p[%0d]", i), dut_p(i), m_p[i]);
        end
    end

    task automatic set_init(input logic [P*WIDTH-1:0] f);
        bus.i_init_bias_o  = f[0    +: N_OUT*WIDTH];
        bus.i_init_bias_hd = f[B_BH +: N_HL_P*WIDTH];
        bus.i_init_wght_o  = f[B_WO +: N_HL_P*N_OUT*WIDTH];
        bus.i_init_wght_hd = f[B_WH +: N_HL_P*N_IN*WIDTH];
    endtask

    task automatic set_delta(input logic [P*WIDTH-1:0] f);
        bus.i_d_bias_o  = f[0    +: N_OUT*WIDTH];
        bus.i_d_bias_hd = f[B_BH +: N_HL_P*WIDTH];
        bus.i_d_wght_o  = f[B_WO +: N_HL_P*N_OUT*WIDTH];
        bus.i_d_wght_hd = f[B_WH +: N_HL_P*N_IN*WIDTH];
    endtask

    function automatic logic [P*WIDTH-1:0] fill(input logic [WIDTH-1:0] w);
        logic [P*WIDTH-1:0] f;
        for (int i = 0; i < P; i++) f[i*WIDTH +: WIDTH] = w;
        return f;
    endfunction

    function automatic logic [WIDTH-1:0] rnd_word();
        case ($urandom_range(0, 3))
            0: return 32'h7FFF_FFF0 | WIDTH'($urandom_range(0, 15));
            1: return 32'h8000_0000 | WIDTH'($urandom_range(0, 15));
            2: return WIDTH'($urandom_range(0, 2047)) - 32'd1024;
            default: return $urandom();
        endcase
    endfunction

    function automatic logic [P*WIDTH-1:0] rnd_flat();
        logic [P*WIDTH-1:0] f;
        for (int i = 0; i < P; i++) f[i*WIDTH +: WIDTH] = rnd_word();
        return f;
    endfunction

    task automatic do_load(input logic [P*WIDTH-1:0] f);
        set_init(f);
        bus.i_load = 1'b1;
        @(negedge clk);
        bus.i_load = 1'b0;
    endtask

    // Pulses i_start; returns cycles from the start edge to o_done (-1 on timeout).
    task automatic run_pass(input bit disturb, output int lat, output int ndone);
        bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        lat   = -1;
        ndone = 0;
        for (int n = 0; n < 30; n++) begin
            if (bus.o_done) begin
                ndone++;
                if (lat < 0) begin
                    lat = n;
                    chk("acc_rst with done", WIDTH'(bus.o_acc_rst), WIDTH'(1));
                end
            end
            if (disturb) begin
                bus.i_start = (n == 5);
                bus.i_load  = (n == 8);
                if (n == 7) set_delta(rnd_flat());
                if (n == 7) bus.i_shift = 5'd0;
            end
            @(negedge clk);
        end
        bus.i_start = 1'b0;
        bus.i_load  = 1'b0;
        if (lat < 0) $display("FAIL done_timeout actual=none required=done");
    endtask

    int lat, nd;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        bus.i_load = 1'b0;
        bus.i_start = 1'b0;
        bus.i_shift = 5'd0;
        set_init('0);
        set_delta('0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset p0", dut_p(0), 32'h0);
        chk("reset p16", dut_p(P-1), 32'h0);
        chk("reset busy", WIDTH'(bus.o_busy), WIDTH'(0));

        do_load(fill(32'h0001_0000));
        chk("load p0", dut_p(0), 32'h0001_0000);
        chk("load p16", dut_p(P-1), 32'h0001_0000);
        chk("load busy", WIDTH'(bus.o_busy), WIDTH'(0));

        set_delta(fill(32'h0000_0400));
        bus.i_shift = 5'd2;
        set_init(fill(32'h0));
        run_pass(1'b0, lat, nd);
        chk("latency", WIDTH'(lat), WIDTH'(18));
        for (int i = 0; i < P; i++) chk($sformatf("pass1 p[%0d]", i), dut_p(i), 32'h0000_FF00);

        do_load(fill(32'h0001_0000));
        set_delta(fill(32'h0000_0400));
        bus.i_shift = 5'd2;
        run_pass(1'b1, lat, nd);
        chk("disturb latency", WIDTH'(lat), WIDTH'(18));
        chk("disturb done count", WIDTH'(nd), WIDTH'(1));
        chk("disturb p0", dut_p(0), 32'h0000_FF00);
        chk("disturb p16", dut_p(P-1), 32'h0000_FF00);

        do_load(fill(32'h8000_0001));
        set_delta(fill(32'h0000_0010));
        bus.i_shift = 5'd0;
        run_pass(1'b0, lat, nd);
`ifdef WBU_SAT_EN
        chk("ovf p0", dut_p(0), 32'h8000_0000);
        chk("ovf p16", dut_p(P-1), 32'h8000_0000);
`else
        chk("ovf p0", dut_p(0), 32'h7FFF_FFF1);
        chk("ovf p16", dut_p(P-1), 32'h7FFF_FFF1);
`endif

        do_load(fill(32'h0000_1000));
        set_delta(fill(32'hFFFF_FF00));
        bus.i_shift = 5'd4;
        run_pass(1'b0, lat, nd);
        chk("neg p0", dut_p(0), 32'h0000_1010);
        chk("neg p16", dut_p(P-1), 32'h0000_1010);

        // Abort while idx = 8.
        do_load(fill(32'h0000_5000));
        set_delta(fill(32'h0000_0100));
        bus.i_shift = 5'd0;
        bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        repeat (9) @(negedge clk);
        chk("pre-abort p7", dut_p(7), 32'h0000_4F00);
        chk("pre-abort p8", dut_p(8), 32'h0000_5000);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort busy", WIDTH'(bus.o_busy), WIDTH'(0));
        for (int i = 0; i < P; i++) chk($sformatf("abort p[%0d]", i), dut_p(i), 32'h0);
        nd = 0;
        for (int n = 0; n < 25; n++) begin
            if (bus.o_done || bus.o_acc_rst) nd++;
            @(negedge clk);
        end
        chk("abort no done", WIDTH'(nd), WIDTH'(0));

        for (int t = 0; t < 30; t++) begin
            int at;
            bit abort;
            do_load(rnd_flat());
            set_delta(rnd_flat());
            bus.i_shift = 5'($urandom_range(0, 31));
            bus.i_start = 1'b1;
            bus.i_load  = ($urandom_range(0, 7) == 0);
            @(negedge clk);
            bus.i_start = 1'b0;
            bus.i_load  = 1'b0;
            abort = ($urandom_range(0, 5) == 0);
            at    = $urandom_range(0, 20);
            for (int c = 0; c < 24; c++) begin
                bus.i_start = ($urandom_range(0, 3) == 0);
                bus.i_load  = ($urandom_range(0, 5) == 0);
                if ($urandom_range(0, 3) == 0) set_delta(rnd_flat());
                if ($urandom_range(0, 3) == 0) set_init(rnd_flat());
                rst = abort && (c == at);
                @(negedge clk);
            end
            rst = 1'b0;
            bus.i_start = 1'b0;
            bus.i_load  = 1'b0;
            begin
                int w;
                w = 0;
                while (bus.o_busy && w < 40) begin
                    @(negedge clk);
                    w++;
                end
                if (bus.o_busy) begin
                    errors++;
                    $display("FAIL idle_timeout actual=busy required=idle");
                end
            end
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
